ivector_respond_arbiter: RTL and testbench
==========================================

# ivector_respond_arbiter

Round-robin scheduler for the ten respond rules of the vector-of-FIFOs block; all respond rules share the single `ind$heard` indication port. Each cycle it takes the per-lane `rule_ready` bits and drives a one-hot `rule_enable` so that at most one lane fires. Grants rotate fairly across lanes. The block also holds a software-configurable lane mask, per-lane saturating grant counters, and a starvation watchdog with sticky flags.

## Interface
- NUM_LANES, 10, number of respond lanes arbitrated (2..16)
- CNT_WIDTH, 16, width of each per-lane grant counter
- STARVE_LIMIT, 64, consecutive ready-but-not-granted cycles before a lane's starve flag sets
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- lane_ready  in  NUM_LANES  respond-rule ready bits (`rule_ready[NUM_LANES-1:0]` of the vector block)
- lane_enable  out  NUM_LANES  one-hot or zero; drives `rule_enable[NUM_LANES-1:0]`
- cfg__ENA  in  1  write lane mask
- cfg_mask  in  NUM_LANES  new mask; bit=1 means the lane is eligible
- cfg__RDY  out  1  mask write accepted
- clr__ENA  in  1  clear all grant counters, wait counters and starve flags
- stat_sel  in  4  lane index for the counter readout
- stat_count  out  CNT_WIDTH  grant count of lane `stat_sel`; 0 if `stat_sel` >= NUM_LANES
- starve  out  NUM_LANES  sticky starvation flags

## Operation
- State:
  - `ptr`: priority pointer, 0..NUM_LANES-1
  - `mask`: NUM_LANES bits
  - `gcnt[i]`: CNT_WIDTH bits per lane
  - `wcnt[i]`: wait counter, saturates at STARVE_LIMIT
  - `starve[i]`: sticky flag
- Eligible set: `elig = lane_ready & mask`.
- Grant (combinational): the first set bit of `elig` scanning `ptr`, `ptr+1`, … with wrap NUM_LANES-1 → 0. `lane_enable` has exactly that bit set. If `elig` is 0, `lane_enable` is 0.
- Pointer: on a grant to lane g, `ptr <= (g == NUM_LANES-1) ? 0 : g+1`. With no grant, `ptr` holds.
- Mask write: `cfg__RDY` = nRST, registered high from the first cycle after reset. When `cfg__ENA && cfg__RDY`, `mask <= cfg_mask` at the edge. The new mask affects grants from the next cycle; the current cycle uses the old mask.
- Grant counters: `gcnt[g]` increments on a grant to g and saturates at 2^CNT_WIDTH-1 (no wrap).
- Watchdog, per lane i each cycle:
  - If `lane_ready[i]` and lane i is not granted, `wcnt[i]` increments, saturating at STARVE_LIMIT. Masked lanes count too; this is intentional and exposes lanes that are masked while ready.
  - Otherwise `wcnt[i] <= 0`.
  - When `wcnt[i]` reaches STARVE_LIMIT, `starve[i] <= 1`. The flag stays set until clr or reset.
- Clear: `clr__ENA` zeroes all `gcnt`, `wcnt` and `starve` at the edge. Clear wins over a coincident increment or flag set. Clear does not affect `ptr`, `mask` or the grant itself.
- Readout: `stat_count` is a combinational mux of `gcnt[stat_sel]`.

## Timing
- Reset (nRST=0 at a CLK edge) sets:
  - `ptr`=0, `mask`=all ones
  - all `gcnt`, `wcnt` = 0, `starve` = 0
  - `cfg__RDY` registered low
- While nRST is low, `lane_enable` is forced to 0 combinationally.
- Reset asserted mid-operation drops any grant in the same cycle. Arbitration restarts from lane 0 on the first cycle after nRST returns high.
- Grant latency: zero cycles. `lane_enable` follows `lane_ready` combinationally within the cycle. `ptr`, counters and flags update at the next edge.
- Simultaneous events:
  - `cfg__ENA` with a grant: the grant uses the old mask.
  - `clr__ENA` with a grant: `ptr` advances, `gcnt` ends at 0.
- Fairness bound: a lane that is continuously eligible is granted within NUM_LANES cycles.
- Counter saturation: at 2^CNT_WIDTH-1, further grants leave `gcnt` unchanged.
- Starve flag timing: for a lane continuously ready and never granted, `starve` rises STARVE_LIMIT+1 edges after `lane_ready` first rises.

## Test plan
- Single lane: after reset, hold `lane_ready`=0x008 for 5 cycles → `lane_enable`=0x008 every cycle, `ptr`=4 after the first edge, `gcnt[3]`=5 (`stat_sel`=3).
- Round robin: `lane_ready`=0x3FF for 20 cycles → `lane_enable` walks 0x001, 0x002, … 0x200, 0x001, …; every `gcnt`=2; no more than one bit set in any cycle.
- Mask: write `cfg_mask`=0x3FE in the same cycle as `lane_ready`=0x001 → lane 0 granted that cycle, 0 grants afterwards. `starve[0]`=1 after 65 edges with STARVE_LIMIT=64.
- Skip and wrap: `ptr`=8, `lane_ready`=0x005 → grant lane 0, then `ptr`=1 → next grant lane 2, then `ptr`=3.
- Clear and saturation: with CNT_WIDTH=4, 20 grants to lane 1 → `stat_count`=15. Then `clr__ENA` coincident with a lane 1 grant → `stat_count`=0, `starve`=0, `ptr`=2.
- Reset mid-run: assert nRST=0 during a 0x3FF stream → `lane_enable`=0 that cycle. After release, the first grant is lane 0, `mask`=0x3FF and counters are 0.

Source files
------------

// File: rtl/ivector_respond_arbiter.sv
// Round-robin scheduler for the respond rules sharing the ind$heard port:
// one-hot grant, lane mask, saturating grant counters and starvation watchdog.
module ivector_respond_arbiter #(
   parameter int NUM_LANES    = 10,
   parameter int CNT_WIDTH    = 16,
   parameter int STARVE_LIMIT = 64
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [NUM_LANES-1:0] lane_ready,
   output logic [NUM_LANES-1:0] lane_enable,
   input  logic                 cfg__ENA,
   input  logic [NUM_LANES-1:0] cfg_mask,
   output logic                 cfg__RDY,
   input  logic                 clr__ENA,
   input  logic [3:0]           stat_sel,
   output logic [CNT_WIDTH-1:0] stat_count,
   output logic [NUM_LANES-1:0] starve
);

   localparam int PTR_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int WCNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [PTR_W-1:0]     LAST_LANE = PTR_W'(NUM_LANES - 1);
   localparam logic [WCNT_W-1:0]    WCNT_MAX  = WCNT_W'(STARVE_LIMIT);
   localparam logic [CNT_WIDTH-1:0] GCNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [NUM_LANES-1:0] ONE_HOT0  = {{(NUM_LANES-1){1'b0}}, 1'b1};

   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [NUM_LANES-1:0] mask_q, mask_d;
   logic                 cfg_rdy_q, cfg_rdy_d;
   logic [CNT_WIDTH-1:0] gcnt_q [NUM_LANES];
   logic [CNT_WIDTH-1:0] gcnt_d [NUM_LANES];
   logic [WCNT_W-1:0]    wcnt_q [NUM_LANES];
   logic [WCNT_W-1:0]    wcnt_d [NUM_LANES];
   logic [NUM_LANES-1:0] starve_q, starve_d;

   logic [NUM_LANES-1:0]   elig_s;
   logic [2*NUM_LANES-1:0] elig_rot_s;
   logic                   grant_vld_s;
   int                     grant_sum_s;
   logic [PTR_W-1:0]       grant_idx_s;
   logic [NUM_LANES-1:0]   grant_oh_s;

   // Grant scan: rotate eligibility so the pointer lane sits at bit 0, then
   // walk downward so the lowest rotated offset (closest to ptr) wins.
   always_comb begin
      elig_s      = lane_ready & mask_q;
      elig_rot_s  = {elig_s, elig_s} >> ptr_q;
      grant_sum_s = 0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         grant_sum_s = elig_rot_s[k] ? (int'(ptr_q) + k) : grant_sum_s;
      end
      grant_sum_s = (grant_sum_s >= NUM_LANES) ? (grant_sum_s - NUM_LANES) : grant_sum_s;
      grant_idx_s = PTR_W'(grant_sum_s);
      grant_vld_s = (|elig_s) & nRST;
      grant_oh_s  = grant_vld_s ? (ONE_HOT0 << grant_idx_s) : {NUM_LANES{1'b0}};
   end

   // Pointer, mask and handshake next state.
   always_comb begin
      ptr_d     = ptr_q;
      mask_d    = mask_q;
      cfg_rdy_d = 1'b1;
      if (grant_vld_s) begin
         ptr_d = (grant_idx_s == LAST_LANE) ? {PTR_W{1'b0}} : (grant_idx_s + 1'b1);
      end else begin
         ptr_d = ptr_q;
      end
      if (cfg__ENA && cfg_rdy_q) begin
         mask_d = cfg_mask;
      end else begin
         mask_d = mask_q;
      end
   end

   // Per-lane grant counters, wait counters and sticky starve flags; clear wins.
   always_comb begin
      starve_d = starve_q;
      for (int i = 0; i < NUM_LANES; i++) begin
         gcnt_d[i] = gcnt_q[i];
         wcnt_d[i] = wcnt_q[i];
         if (clr__ENA) begin
            gcnt_d[i]   = {CNT_WIDTH{1'b0}};
            wcnt_d[i]   = {WCNT_W{1'b0}};
            starve_d[i] = 1'b0;
         end else begin
            if (grant_oh_s[i] && (gcnt_q[i] != GCNT_MAX)) begin
               gcnt_d[i] = gcnt_q[i] + 1'b1;
            end else begin
               gcnt_d[i] = gcnt_q[i];
            end
            // Masked-but-ready lanes also accumulate wait time.
            if (lane_ready[i] && !grant_oh_s[i]) begin
               wcnt_d[i] = (wcnt_q[i] == WCNT_MAX) ? wcnt_q[i] : (wcnt_q[i] + 1'b1);
            end else begin
               wcnt_d[i] = {WCNT_W{1'b0}};
            end
            starve_d[i] = starve_q[i] | (wcnt_q[i] == WCNT_MAX);
         end
      end
   end

   // Counter readout mux; out-of-range selects read as zero.
   always_comb begin
      stat_count = {CNT_WIDTH{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
         stat_count = (stat_sel == 4'(i)) ? gcnt_q[i] : stat_count;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         ptr_q     <= {PTR_W{1'b0}};
         mask_q    <= {NUM_LANES{1'b1}};
         cfg_rdy_q <= 1'b0;
         starve_q  <= {NUM_LANES{1'b0}};
         for (int i = 0; i < NUM_LANES; i++) begin
            gcnt_q[i] <= {CNT_WIDTH{1'b0}};
            wcnt_q[i] <= {WCNT_W{1'b0}};
         end
      end else begin
         ptr_q     <= ptr_d;
         mask_q    <= mask_d;
         cfg_rdy_q <= cfg_rdy_d;
         starve_q  <= starve_d;
         for (int i = 0; i < NUM_LANES; i++) begin
            gcnt_q[i] <= gcnt_d[i];
            wcnt_q[i] <= wcnt_d[i];
         end
      end
   end

   assign lane_enable = grant_oh_s;
   assign cfg__RDY    = cfg_rdy_q;
   assign starve      = starve_q;

endmodule

// File: tb/tb_ivector_respond_arbiter.sv
// Directed plus randomized bench for ivector_respond_arbiter against a
// lane-level behavioural model (pointer scan, counters, watchdog).
module tb_ivector_respond_arbiter;

   localparam int N  = 10;
   localparam int CW = 4;
   localparam int SL = 64;

   logic          CLK = 1'b0;
   logic          nRST;
   logic [N-1:0]  lane_ready;
   logic [N-1:0]  lane_enable;
   logic          cfg__ENA;
   logic [N-1:0]  cfg_mask;
   logic          cfg__RDY;
   logic          clr__ENA;
   logic [3:0]    stat_sel;
   logic [CW-1:0] stat_count;
   logic [N-1:0]  starve;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         m_ptr;
   logic [N-1:0] m_mask;
   int         m_gcnt [N];
   int         m_wcnt [N];
   logic [N-1:0] m_starve;
   logic       m_rdy;

   ivector_respond_arbiter #(.NUM_LANES(N), .CNT_WIDTH(CW), .STARVE_LIMIT(SL)) dut (
      .CLK(CLK), .nRST(nRST), .lane_ready(lane_ready), .lane_enable(lane_enable),
      .cfg__ENA(cfg__ENA), .cfg_mask(cfg_mask), .cfg__RDY(cfg__RDY),
      .clr__ENA(clr__ENA), .stat_sel(stat_sel), .stat_count(stat_count), .starve(starve)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_mask = '1;
      m_starve = '0;
      m_rdy = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_gcnt[i] = 0;
         m_wcnt[i] = 0;
      end
   endtask

   // First eligible lane starting from the pointer, wrapping; -1 if none.
   function automatic int model_grant(input logic [N-1:0] elig);
      for (int k = 0; k < N; k++) begin
         int l;
         l = (m_ptr + k) % N;
         if (elig[l]) return l;
      end
      return -1;
   endfunction

   task automatic step(input logic [N-1:0] rdy, input logic ce, input logic [N-1:0] cm,
                       input logic clr, input logic [3:0] sel, input logic rst_n);
      int g;
      logic [N-1:0] exp_en;
      logic [CW-1:0] exp_cnt;
      @(negedge CLK);
      lane_ready = rdy; cfg__ENA = ce; cfg_mask = cm;
      clr__ENA = clr; stat_sel = sel; nRST = rst_n;
      #1;
      g = rst_n ? model_grant(rdy & m_mask) : -1;
      for (int i = 0; i < N; i++) exp_en[i] = (i == g);
      exp_cnt = (int'(sel) < N) ? CW'(m_gcnt[int'(sel)]) : '0;
      chk("lane_enable", 32'(lane_enable), 32'(exp_en));
      chk("onehot", 32'($countones(lane_enable) <= 1), 32'd1);
      chk("stat_count", 32'(stat_count), 32'(exp_cnt));
      chk("starve", 32'(starve), 32'(m_starve));
      chk("cfg_rdy", 32'(cfg__RDY), 32'(m_rdy));
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < N; i++) begin
            if (clr) begin
               m_gcnt[i] = 0; m_wcnt[i] = 0; m_starve[i] = 1'b0;
            end else begin
               if (m_wcnt[i] == SL) m_starve[i] = 1'b1;
               if (i == g && m_gcnt[i] < (1 << CW) - 1) m_gcnt[i]++;
               if (rdy[i] && i != g) m_wcnt[i] = (m_wcnt[i] < SL) ? m_wcnt[i] + 1 : SL;
               else m_wcnt[i] = 0;
            end
         end
         if (ce && m_rdy) m_mask = cm;
         if (g >= 0) m_ptr = (g + 1) % N;
         m_rdy = 1'b1;
      end
   endtask

   initial begin
      nRST = 1'b0; lane_ready = '0; cfg__ENA = 1'b0; cfg_mask = '0;
      clr__ENA = 1'b0; stat_sel = 4'd0;
      repeat (2) @(posedge CLK);
      model_reset();

      // Reset state, then release
      step(10'h3FF, 1'b0, '0, 1'b0, 4'd0, 1'b0);
      step(10'h000, 1'b0, '0, 1'b0, 4'd0, 1'b1);

      // Single lane
      repeat (5) step(10'h008, 1'b0, '0, 1'b0, 4'd3, 1'b1);
      step(10'h000, 1'b0, '0, 1'b0, 4'd3, 1'b1);
      chk("gcnt3_single", 32'(stat_count), 32'd5);

      // Round robin after a fresh reset
      step(10'h000, 1'b0, '0, 1'b0, 4'd0, 1'b0);
      for (int c = 0; c < 20; c++) step(10'h3FF, 1'b0, '0, 1'b0, 4'(c % 16), 1'b1);
      for (int i = 0; i < N; i++) step(10'h000, 1'b0, '0, 1'b0, 4'(i), 1'b1);
      step(10'h000, 1'b0, '0, 1'b0, 4'd12, 1'b1);

      // Mask write coincident with lane 0 request, then starvation of lane 0
      step(10'h001, 1'b1, 10'h3FE, 1'b0, 4'd0, 1'b1);
      repeat (66) step(10'h001, 1'b0, '0, 1'b0, 4'd0, 1'b1);
      step(10'h000, 1'b1, 10'h3FF, 1'b0, 4'd0, 1'b1);

      // Skip and wrap: park ptr at 8, then 0x005 grants 0 then 2, then ptr=3
      step(10'h080, 1'b0, '0, 1'b0, 4'd7, 1'b1);
      step(10'h005, 1'b0, '0, 1'b0, 4'd0, 1'b1);
      step(10'h005, 1'b0, '0, 1'b0, 4'd2, 1'b1);
      step(10'h3FF, 1'b0, '0, 1'b0, 4'd3, 1'b1);

      // Saturation at 15, then clear coincident with a lane 1 grant
      repeat (20) step(10'h002, 1'b0, '0, 1'b0, 4'd1, 1'b1);
      step(10'h002, 1'b0, '0, 1'b1, 4'd1, 1'b1);
      step(10'h3FF, 1'b0, '0, 1'b0, 4'd1, 1'b1);

      // Reset mid-stream
      repeat (3) step(10'h3FF, 1'b0, '0, 1'b0, 4'd4, 1'b1);
      step(10'h3FF, 1'b0, '0, 1'b0, 4'd4, 1'b0);
      step(10'h3FF, 1'b0, '0, 1'b0, 4'd0, 1'b1);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0] r, m;
         logic ce, cl, rs;
         r  = N'($urandom_range(0, 1023));
         m  = N'($urandom_range(0, 1023)) | N'($urandom_range(0, 1023));
         ce = ($urandom_range(0, 15) == 0);
         cl = ($urandom_range(0, 31) == 0);
         rs = ($urandom_range(0, 127) != 0);
         step(r, ce, m, cl, 4'($urandom_range(0, 15)), rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
